ram_fifo_ctrl: RTL and testbench

//  Upstream controller that turns the 16x8 single-port synchronous RAM into a stream FIFO.

---
 rtl/ram_fifo_ctrl_pkg.sv | 13 +
 rtl/ram_fifo_ctrl_out_stage.sv | 27 ++
 rtl/ram_fifo_ctrl.sv | 88 ++++++++
 tb/tb_ram_fifo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing defaults and port-grant encodings for the RAM-backed stream FIFO.
// Used by the controller and the bench.
package ram_fifo_ctrl_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 2**DEF_ADDR_W;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;
endpackage

// File: rtl/ram_fifo_ctrl_out_stage.sv
// One-entry output register that holds the FIFO head.
// It is loaded from RAM read data and drained through the out_valid/out_ready handshake.
module fifo_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  // A load never lands on an unconsumed word: the read that produced it was only granted
  // once the register was free or being drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= ld_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// Stream FIFO controller that owns the single port of an external synchronous RAM.
// It holds the pointers, the occupancy count, write/read arbitration and the output register.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_pend, last_wr;
  logic              wr_req, rd_req;
  gnt_e              gnt;

  // Occupancy alone decides full/empty, so pointer equality is never ambiguous.
  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign empty  = (count == '0) && !out_valid && !rd_pend;
  assign wr_req = in_valid && !full;
  assign rd_req = (count != '0) && !rd_pend && (!out_valid || out_ready);

  // When both sides ask, the side that did not win last time gets the port.
  always_comb begin
    gnt = GNT_IDLE;
    if (!reset) begin
      if (wr_req && rd_req) gnt = last_wr ? GNT_RD : GNT_WR;
      else if (wr_req)      gnt = GNT_WR;
      else if (rd_req)      gnt = GNT_RD;
    end
  end

  assign ram_we   = (gnt == GNT_WR);
  assign ram_re   = (gnt == GNT_RD);
  assign in_ready = ram_we;
  assign ram_addr = ram_we ? wr_ptr : rd_ptr;
  assign ram_din  = in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_pend <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      rd_pend <= (gnt == GNT_RD);
      case (gnt)
        GNT_WR: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count   <= count + 1'b1;
          last_wr <= 1'b1;
        end
        GNT_RD: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count   <= count - 1'b1;
          last_wr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fifo_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_pend),
    .ld_data  (ram_dout),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data)
  );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 16x8 RAM beside it, a vector table,
// directed corner sequences and random traffic checked against a word-queue model.
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;

  logic       clk, reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [4:0] count;
  logic       full, empty, ram_we, ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [7:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];

  ram_fifo_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .full(full), .empty(empty), .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [1:0] gnt_obs();
    return ram_we ? GNT_WR : (ram_re ? GNT_RD : GNT_IDLE);
  endfunction

  // Word-level model: every accepted word must come out once, in order; the FIFO
  // is empty exactly when no accepted word is still outstanding.
  always @(negedge clk) begin
    #4;
    if (reset) begin
      q.delete();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_re", 32'(ram_re), 0);
    end else begin
      chk("one_port", 32'(ram_we && ram_re), 0);
      chk("empty_model", 32'(empty), 32'(q.size() == 0));
      chk("full_vs_count", 32'(full), 32'(count == 5'd16));
      chk("count_max", 32'(count <= 5'd16), 1);
      if (out_valid && !out_ready) chk("bp_no_re", 32'(ram_re), 0);
      if (in_ready) chk("in_ready_qual", 32'(in_valid && !full), 1);
      if (in_valid && in_ready) q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail("pop_on_empty_model");
        else chk("order", 32'(out_data), 32'(q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a falling edge; returns at a falling edge after the word was taken.
  task automatic push(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    #1;
    while (!in_ready && n < 64) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 64) fail("push_timeout");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    while (!empty && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_model", 32'(q.size()), 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic [1:0] e_gnt;
    logic       e_ov;
    logic [7:0] e_od;
    logic [4:0] e_cnt;
    logic       e_empty;
  } vec_t;

  function automatic vec_t mk(int iv, int d, int ordy, int ir, int g, int ov, int od, int cnt, int em);
    vec_t v;
    v.iv = iv[0]; v.d = d[7:0]; v.ordy = ordy[0]; v.e_ir = ir[0]; v.e_gnt = g[1:0];
    v.e_ov = ov[0]; v.e_od = od[7:0]; v.e_cnt = cnt[4:0]; v.e_empty = em[0];
    return v;
  endfunction

  initial begin
    vec_t tbl[15];
    logic [1:0] g, gp;
    logic [7:0] hold;
    int v, budget, n;
    int pi[4] = '{75, 25, 50, 75};
    int po[4] = '{25, 75, 50, 75};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #20 reset = 1'b0;

    // Values are sampled before the edge with the row's inputs applied.
    //            iv  d  ordy  ir gnt  ov od cnt empty
    tbl[0]  = mk(1, 43, 0,   1, 1,   0, 0,  0, 1);
    tbl[1]  = mk(1, 53, 0,   0, 2,   0, 0,  1, 0);
    tbl[2]  = mk(1, 53, 0,   1, 1,   0, 0,  0, 0);
    tbl[3]  = mk(1,  3, 0,   1, 1,   1, 43, 1, 0);
    tbl[4]  = mk(0,  0, 0,   0, 0,   1, 43, 2, 0);
    tbl[5]  = mk(0,  0, 1,   0, 2,   1, 43, 2, 0);
    tbl[6]  = mk(0,  0, 1,   0, 0,   0, 0,  1, 0);
    tbl[7]  = mk(0,  0, 0,   0, 0,   1, 53, 1, 0);
    tbl[8]  = mk(1,  4, 1,   1, 1,   1, 53, 1, 0);
    tbl[9]  = mk(0,  0, 1,   0, 2,   0, 0,  2, 0);
    tbl[10] = mk(0,  0, 1,   0, 0,   0, 0,  1, 0);
    tbl[11] = mk(0,  0, 1,   0, 2,   1, 3,  1, 0);
    tbl[12] = mk(0,  0, 0,   0, 0,   0, 0,  0, 0);
    tbl[13] = mk(0,  0, 1,   0, 0,   1, 4,  0, 0);
    tbl[14] = mk(0,  0, 0,   0, 0,   0, 0,  0, 1);

    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_empty", 32'(empty), 1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_obs()), 32'(tbl[i].e_gnt));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
    end

    // Fill: 17 words (one in the output register, 16 in RAM), then 69 is held off.
    do_reset();
    for (int i = 0; i <= 16; i++) push(8'(i));
    in_valid = 1'b1; in_data = 8'd69;
    #1;
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_out_data", 32'(out_data), 0);
    for (int i = 0; i < 3; i++) begin
      chk("fill_held_off", 32'(in_ready), 0);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("fill_pop_rd", 32'(gnt_obs()), 32'(GNT_RD));
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("fill_slot_freed", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Both sides requesting every cycle: the port alternates and never idles.
    do_reset();
    push(8'd10);
    push(8'd11);
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'd12;
    gp = GNT_IDLE;
    for (int i = 0; i < 8; i++) begin
      #1;
      g = gnt_obs();
      chk("alt_busy", 32'(g != GNT_IDLE), 1);
      if (i > 0) chk("alt_switch", 32'(g != gp), 1);
      gp = g;
      @(negedge clk);
      if (g == GNT_WR) in_data = in_data + 8'd1;
    end
    drain();

    // Backpressure: the head word stays put and no read is issued behind it.
    do_reset();
    push(8'd5); push(8'd6); push(8'd7);
    n = 0;
    #1;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_valid_seen", 32'(out_valid), 1);
    hold = out_data;
    chk("bp_head", 32'(hold), 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_stable", 32'(out_data), 5);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_re", 32'(ram_re), 0);
    end
    @(negedge clk);
    drain();

    // Wrap-around: values 1..40 pass through with random consumer readiness.
    do_reset();
    v = 1; budget = 0; in_valid = 1'b1; in_data = 8'd1;
    while (v <= 40 && budget < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) v++;
      @(negedge clk);
      budget++;
      in_data = 8'(v); in_valid = (v <= 40);
    end
    chk("wrap_all_pushed", 32'(v), 41);
    drain();

    // Random traffic in segments biased toward fill, drain, balance and heavy flow.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        in_valid  = ($urandom_range(0, 99) < pi[s]);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(0, 99) < po[s]);
      end
    end
    @(negedge clk);
    drain();

    // Reset the cycle after a read grant: pending read and output word are discarded.
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rr_read_granted", 32'(ram_re), 1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    #1;
    chk("rr_out_valid", 32'(out_valid), 0);
    chk("rr_count", 32'(count), 0);
    chk("rr_empty", 32'(empty), 1);
    chk("rr_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    push(8'd43);
    n = 0;
    #1;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("rr_first_valid", 32'(out_valid), 1);
    chk("rr_first_word", 32'(out_data), 43);
    @(negedge clk);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
